// File: rtl/rx_bit_decoder.sv
// USB receive bit decoder: NRZI decode, bit-stuff removal, byte assembly
// (LSB first) and end-of-packet detection on strobed D+/D- samples.
// Optional feature macro: RX_STUFF_ERR_EN -- flags a decoded 1 in the
// stuff-bit slot on stuff_err; when undefined stuff_err is tied low.
module rx_bit_decoder #(
  parameter int unsigned STUFF_LIMIT = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_enable,
  input  logic       shift_enable,
  input  logic       d_plus_sync,
  input  logic       d_minus_sync,
  output logic [7:0] rx_data,
  output logic       byte_valid,
  output logic       eop,
  output logic       stuff_err
);

  localparam int unsigned ONES_W = $clog2(STUFF_LIMIT + 1);
  localparam int unsigned BYTE_W = 8;
  // The oldest received bit falls off the low end when the byte completes,
  // so only the upper seven bits of the assembly register are kept.
  localparam int unsigned SHR_W  = BYTE_W - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    SE0_1 = 2'd2,
    EOP   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [SHR_W-1:0]    shreg_q, shreg_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [ONES_W-1:0]   ones_cnt_q, ones_cnt_d;
  logic                prev_level_q, prev_level_d;
  logic [BYTE_W-1:0]   rx_data_q, rx_data_d;
  logic                byte_valid_q, byte_valid_d;
  logic                eop_q, eop_d;
`ifdef RX_STUFF_ERR_EN
  logic                stuff_err_q, stuff_err_d;
`endif

  logic                se0;
  logic                dbit;

  // Sample classification; D+=D-=1 is treated as J, so D+ alone gives the level.
  assign se0  = ~d_plus_sync & ~d_minus_sync;
  assign dbit = (d_plus_sync == prev_level_q);

  // Next-state, datapath and pulse logic.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    ones_cnt_d   = ones_cnt_q;
    prev_level_d = prev_level_q;
    rx_data_d    = rx_data_q;
    byte_valid_d = 1'b0;
    eop_d        = 1'b0;
`ifdef RX_STUFF_ERR_EN
    stuff_err_d  = 1'b0;
`endif

    if (!rx_enable) begin
      // Disable wins over any coincident strobe.
      state_d      = IDLE;
      shreg_d      = '0;
      bit_cnt_d    = '0;
      ones_cnt_d   = '0;
      prev_level_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d      = RECV;
          shreg_d      = '0;
          bit_cnt_d    = '0;
          ones_cnt_d   = '0;
          prev_level_d = 1'b1;
        end

        RECV: begin
          if (shift_enable) begin
            if (se0) begin
              state_d = SE0_1;
            end else begin
              prev_level_d = d_plus_sync;
              if (ones_cnt_q == ONES_W'(STUFF_LIMIT)) begin
                // Stuff-bit slot: dropped without advancing the byte.
                ones_cnt_d = '0;
`ifdef RX_STUFF_ERR_EN
                stuff_err_d = dbit;
`endif
              end else begin
                ones_cnt_d = dbit ? ONES_W'(ones_cnt_q + ONES_W'(1)) : '0;
                shreg_d    = {dbit, shreg_q[SHR_W-1:1]};
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                  rx_data_d    = {dbit, shreg_q};
                  byte_valid_d = 1'b1;
                end
              end
            end
          end
        end

        SE0_1: begin
          if (shift_enable) begin
            if (se0) begin
              state_d    = EOP;
              eop_d      = 1'b1;
              shreg_d    = '0;
              bit_cnt_d  = '0;
              ones_cnt_d = '0;
            end else begin
              state_d      = RECV;
              prev_level_d = d_plus_sync;
            end
          end
        end

        EOP: begin
          if (shift_enable && !se0) begin
            prev_level_d = d_plus_sync;
            if (d_plus_sync) begin
              state_d = RECV;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      ones_cnt_q   <= '0;
      prev_level_q <= 1'b1;
      rx_data_q    <= '0;
      byte_valid_q <= 1'b0;
      eop_q        <= 1'b0;
`ifdef RX_STUFF_ERR_EN
      stuff_err_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      ones_cnt_q   <= ones_cnt_d;
      prev_level_q <= prev_level_d;
      rx_data_q    <= rx_data_d;
      byte_valid_q <= byte_valid_d;
      eop_q        <= eop_d;
`ifdef RX_STUFF_ERR_EN
      stuff_err_q  <= stuff_err_d;
`endif
    end
  end

  assign rx_data    = rx_data_q;
  assign byte_valid = byte_valid_q;
  assign eop        = eop_q;
`ifdef RX_STUFF_ERR_EN
  assign stuff_err  = stuff_err_q;
`else
  assign stuff_err  = 1'b0;
`endif

endmodule

// File: tb/tb_rx_bit_decoder.sv
// Self-checking bench for rx_bit_decoder: NRZI line encoder with stuffing,
// expected-byte scoreboard drained by a byte_valid monitor.
module tb_rx_bit_decoder;

  localparam int unsigned STUFF = 6;
`ifdef RX_STUFF_ERR_EN
  localparam logic EXP_SE = 1'b1;
`else
  localparam logic EXP_SE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_enable;
  logic       shift_enable;
  logic       dp;
  logic       dm;
  logic [7:0] rx_data;
  logic       byte_valid;
  logic       eop;
  logic       stuff_err;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp_b;
  int bv_cnt = 0, eop_cnt = 0, se_cnt = 0;
  logic bv_prev = 1'b0, eop_prev = 1'b0, se_prev = 1'b0;

  logic line_lvl = 1'b1;
  int   tb_ones  = 0;
  logic last_bv, last_eop, last_se;

  always #5 clk = ~clk;

  rx_bit_decoder #(.STUFF_LIMIT(STUFF)) dut (
    .clk          (clk),
    .rst          (rst),
    .rx_enable    (rx_enable),
    .shift_enable (shift_enable),
    .d_plus_sync  (dp),
    .d_minus_sync (dm),
    .rx_data      (rx_data),
    .byte_valid   (byte_valid),
    .eop          (eop),
    .stuff_err    (stuff_err)
  );

  // Scoreboard drain and one-clock pulse-width checks.
  always @(negedge clk) begin
    if (byte_valid === 1'b1) begin
      bv_cnt++;
      checks++;
      if (bv_prev) begin
        errors++;
        $display("FAIL byte_valid_width: high for 2 clks, required 1");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL spurious_byte: rx_data=%h, no byte expected", rx_data);
      end else begin
        exp_b = exp_q.pop_front();
        if (rx_data !== exp_b) begin
          errors++;
          $display("FAIL byte_value: rx_data=%h required=%h", rx_data, exp_b);
        end
      end
    end
    if (eop === 1'b1) begin
      eop_cnt++;
      checks++;
      if (eop_prev) begin
        errors++;
        $display("FAIL eop_width: high for 2 clks, required 1");
      end
    end
    if (stuff_err === 1'b1) begin
      se_cnt++;
      checks++;
      if (se_prev) begin
        errors++;
        $display("FAIL stuff_err_width: high for 2 clks, required 1");
      end
    end
    bv_prev  = (byte_valid === 1'b1);
    eop_prev = (eop === 1'b1);
    se_prev  = (stuff_err === 1'b1);
  end

  // One strobe, five clocks per bit; captures pulses one clock after the strobe edge.
  task automatic strobe(input logic p, input logic m);
    @(negedge clk);
    dp = p; dm = m; shift_enable = 1'b1;
    @(negedge clk);
    shift_enable = 1'b0;
    last_bv  = byte_valid;
    last_eop = eop;
    last_se  = stuff_err;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_raw(input logic b);
    if (!b) line_lvl = ~line_lvl;
    strobe(line_lvl, ~line_lvl);
    if (b) tb_ones++;
    else   tb_ones = 0;
  endtask

  task automatic send_bit(input logic b);
    if (tb_ones == int'(STUFF)) send_raw(1'b0);
    send_raw(b);
  endtask

  task automatic send_byte(input logic [7:0] v, input bit push);
    if (push) exp_q.push_back(v);
    for (int i = 0; i < 8; i++) send_bit(v[i]);
  endtask

  task automatic restart();
    @(negedge clk);
    rx_enable = 1'b0; dp = 1'b1; dm = 1'b0;
    repeat (2) @(negedge clk);
    rx_enable = 1'b1;
    repeat (2) @(negedge clk);
    line_lvl = 1'b1;
    tb_ones  = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_enable = 1'b0; shift_enable = 1'b0; dp = 1'b1; dm = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got=%h required=00", rx_data); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL reset_byte_valid: got=%b required=0", byte_valid); end
    checks++; if (eop !== 1'b0) begin errors++; $display("FAIL reset_eop: got=%b required=0", eop); end
    checks++; if (stuff_err !== 1'b0) begin errors++; $display("FAIL reset_stuff_err: got=%b required=0", stuff_err); end
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    int b0;
    restart();
    b0 = bv_cnt;
    send_byte(8'hA5, 1'b1);
    checks++; if (last_bv !== 1'b1) begin errors++; $display("FAIL a5_latency: byte_valid=%b 1 clk after 8th strobe, required 1", last_bv); end
    repeat (5) @(negedge clk);
    checks++; if (bv_cnt - b0 != 1) begin errors++; $display("FAIL a5_pulses: got=%0d required=1", bv_cnt - b0); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL a5_data: got=%h required=a5", rx_data); end
  endtask

  task automatic test_stuffing();
    int b0, s0;
    restart();
    b0 = bv_cnt; s0 = se_cnt;
    send_byte(8'hFF, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (10) @(negedge clk);
    checks++; if (bv_cnt - b0 != 2) begin errors++; $display("FAIL stuff_pulses: got=%0d required=2", bv_cnt - b0); end
    checks++; if (se_cnt - s0 != 0) begin errors++; $display("FAIL stuff_legal_err: got=%0d required=0", se_cnt - s0); end
    checks++; if (rx_data !== 8'h01) begin errors++; $display("FAIL stuff_hold: got=%h required=01", rx_data); end
  endtask

  task automatic test_stuff_violation();
    int b0, s0;
    restart();
    b0 = bv_cnt; s0 = se_cnt;
    for (int i = 0; i < 7; i++) send_raw(1'b1);
    checks++; if (last_se !== EXP_SE) begin errors++; $display("FAIL viol_pulse: stuff_err=%b after 7th strobe, required %b", last_se, EXP_SE); end
    // Six accepted ones plus two zeros complete a byte only if the 7th was dropped.
    exp_q.push_back(8'h3F);
    send_raw(1'b0);
    send_raw(1'b0);
    repeat (5) @(negedge clk);
    checks++; if (bv_cnt - b0 != 1) begin errors++; $display("FAIL viol_pulses: got=%0d required=1", bv_cnt - b0); end
    checks++; if (se_cnt - s0 != int'(EXP_SE)) begin errors++; $display("FAIL viol_count: got=%0d required=%0d", se_cnt - s0, int'(EXP_SE)); end
  endtask

  task automatic test_eop();
    int b0, e0;
    logic [3:0] bits;
    restart();
    b0 = bv_cnt; e0 = eop_cnt;
    bits = 4'b1101;
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    strobe(1'b0, 1'b0);
    checks++; if (last_eop !== 1'b0) begin errors++; $display("FAIL eop_early: eop=%b after 1st SE0, required 0", last_eop); end
    strobe(1'b0, 1'b0);
    checks++; if (last_eop !== 1'b1) begin errors++; $display("FAIL eop_pulse: eop=%b after 2nd SE0, required 1", last_eop); end
    strobe(1'b1, 1'b0);
    line_lvl = 1'b1; tb_ones = 0;
    checks++; if (bv_cnt - b0 != 0) begin errors++; $display("FAIL eop_partial: byte_valid pulses=%0d required=0", bv_cnt - b0); end
    send_byte(8'h3C, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if (eop_cnt - e0 != 1) begin errors++; $display("FAIL eop_count: got=%0d required=1", eop_cnt - e0); end
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL eop_next: got=%h required=3c", rx_data); end
  endtask

  task automatic test_reset_mid_byte();
    int b0;
    logic [3:0] bits;
    restart();
    bits = 4'b0110;
    for (int i = 0; i < 4; i++) send_bit(bits[i]);
    b0 = bv_cnt;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rst_rx_data: got=%h required=00", rx_data); end
    checks++; if (byte_valid !== 1'b0) begin errors++; $display("FAIL rst_byte_valid: got=%b required=0", byte_valid); end
    checks++; if (eop !== 1'b0) begin errors++; $display("FAIL rst_eop: got=%b required=0", eop); end
    checks++; if (stuff_err !== 1'b0) begin errors++; $display("FAIL rst_stuff_err: got=%b required=0", stuff_err); end
    @(negedge clk);
    rst = 1'b0; dp = 1'b1; dm = 1'b0;
    repeat (2) @(negedge clk);
    line_lvl = 1'b1; tb_ones = 0;
    send_byte(8'h5A, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if (bv_cnt - b0 != 1) begin errors++; $display("FAIL rst_pulses: got=%0d required=1", bv_cnt - b0); end
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL rst_next: got=%h required=5a", rx_data); end
  endtask

  task automatic test_enable_drop();
    int b0;
    logic [4:0] bits;
    restart();
    b0 = bv_cnt;
    bits = 5'b01011;
    for (int i = 0; i < 5; i++) send_bit(bits[i]);
    // Drop enable on the same clock as a strobe; the sample must be ignored.
    @(negedge clk);
    rx_enable = 1'b0; shift_enable = 1'b1; dp = 1'b0; dm = 1'b1;
    @(negedge clk);
    shift_enable = 1'b0; dp = 1'b1; dm = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rx_data !== 8'h5A) begin errors++; $display("FAIL en_retain: got=%h required=5a", rx_data); end
    rx_enable = 1'b1;
    repeat (2) @(negedge clk);
    line_lvl = 1'b1; tb_ones = 0;
    send_byte(8'hC3, 1'b1);
    repeat (5) @(negedge clk);
    checks++; if (bv_cnt - b0 != 1) begin errors++; $display("FAIL en_pulses: got=%0d required=1", bv_cnt - b0); end
    checks++; if (rx_data !== 8'hC3) begin errors++; $display("FAIL en_data: got=%h required=c3", rx_data); end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_stuffing();
    test_stuff_violation();
    test_eop();
    test_reset_mid_byte();
    test_enable_drop();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_bytes: %0d expected bytes never received, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
